// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
// Control sequencer for the 10-bit processor. One instruction is latched per
// EXEC request in step T0 and then walked through one or two execution steps.
// Each step drives the four-entry register file ports, the ALU function and
// the bus strobes.
//
// Ports
//   CLKb   in   1   system clock, rising edge active
//   Rstn   in   1   asynchronous active-low reset
//   EXEC   in   1   execute request, sampled only in T0
//   INSTR  in  10   [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] reserved
//   WRA    out  2   write address          ENW   out 1  write enable
//   RDA0   out  2   read address port 0    ENR0  out 1  read enable port 0
//   RDA1   out  2   read address port 1    ENR1  out 1  read enable port 1
//   FN     out  3   ALU function           Gin   out 1  load G register
//   Gout   out  1   G onto bus             Extrn out 1  external data onto bus
//   DONE   out  1   final step             BUSY  out 1  step is not T0
//   STEP   out  2   current step (00 T0, 01 T1, 10 T2)
//
// All outputs are a combinational decode of the step register and IR, so a
// reset forces every output to zero without waiting for a clock edge.
// -----------------------------------------------------------------------------
module regfile_sequencer (
   input  logic       CLKb,
   input  logic       Rstn,
   input  logic       EXEC,
   input  logic [9:0] INSTR,
   output logic [1:0] WRA,
   output logic [1:0] RDA0,
   output logic [1:0] RDA1,
   output logic       ENW,
   output logic       ENR0,
   output logic       ENR1,
   output logic [2:0] FN,
   output logic       Gin,
   output logic       Gout,
   output logic       Extrn,
   output logic       DONE,
   output logic       BUSY,
   output logic [1:0] STEP
);

   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10
   } step_e;

   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_COPY = 4'b0001;
   localparam logic [3:0] OP_INV  = 4'b0111;

   step_e      step_q, step_d;
   logic [9:0] ir_q, ir_d;

   logic [3:0] op_s;
   logic [1:0] rx_s;
   logic [1:0] ry_s;

   assign op_s = ir_q[9:6];
   assign rx_s = ir_q[5:4];
   assign ry_s = ir_q[3:2];

   // ALU function for opcodes 0010..0111; ADD..XOR map to 000..100, INV to 101.
   function automatic logic [2:0] alu_fn(input logic [3:0] op);
      logic [2:0] fn;
      case (op)
         4'b0010: fn = 3'b000;
         4'b0011: fn = 3'b001;
         4'b0100: fn = 3'b010;
         4'b0101: fn = 3'b011;
         4'b0110: fn = 3'b100;
         4'b0111: fn = 3'b101;
         default: fn = 3'b000;
      endcase
      return fn;
   endfunction

   // True for opcodes that need the two-step read/compute then write-back flow.
   function automatic logic is_alu(input logic [3:0] op);
      return (op >= 4'b0010) && (op <= 4'b0111);
   endfunction

   // Next step and instruction register.
   always_comb begin
      step_d = step_q;
      ir_d   = ir_q;
      case (step_q)
         T0: begin
            if (EXEC) begin
               ir_d   = INSTR;
               step_d = T1;
            end else begin
               step_d = T0;
            end
         end
         T1: begin
            if (is_alu(op_s)) begin
               step_d = T2;
            end else begin
               step_d = T0;
            end
         end
         T2:      step_d = T0;
         default: step_d = T0;
      endcase
   end

   // Step and IR registers; IR only changes on an accepted EXEC in T0.
   always_ff @(posedge CLKb or negedge Rstn) begin
      if (!Rstn) begin
         step_q <= T0;
         ir_q   <= 10'd0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
      end
   end

   // Output decode of the current step and latched instruction.
   always_comb begin
      WRA   = 2'b00;
      RDA0  = 2'b00;
      RDA1  = 2'b00;
      ENW   = 1'b0;
      ENR0  = 1'b0;
      ENR1  = 1'b0;
      FN    = 3'b000;
      Gin   = 1'b0;
      Gout  = 1'b0;
      Extrn = 1'b0;
      DONE  = 1'b0;
      case (step_q)
         T1: begin
            if (op_s == OP_LOAD) begin
               Extrn = 1'b1;
               ENW   = 1'b1;
               WRA   = rx_s;
               DONE  = 1'b1;
            end else if (op_s == OP_COPY) begin
               // Register file reads combinationally, so Q0 is on the bus
               // in time for the same-cycle write.
               ENR0 = 1'b1;
               RDA0 = ry_s;
               ENW  = 1'b1;
               WRA  = rx_s;
               DONE = 1'b1;
            end else if (op_s == OP_INV) begin
               ENR1 = 1'b1;
               RDA1 = ry_s;
               FN   = alu_fn(op_s);
               Gin  = 1'b1;
            end else if (is_alu(op_s)) begin
               ENR0 = 1'b1;
               RDA0 = rx_s;
               ENR1 = 1'b1;
               RDA1 = ry_s;
               FN   = alu_fn(op_s);
               Gin  = 1'b1;
            end else begin
               DONE = 1'b1;
            end
         end
         T2: begin
            // FN stays at the opcode value while G is written back.
            FN   = alu_fn(op_s);
            Gout = 1'b1;
            ENW  = 1'b1;
            WRA  = rx_s;
            DONE = 1'b1;
         end
         default: begin
            DONE = 1'b0;
         end
      endcase
   end

   assign BUSY = (step_q != T0);
   assign STEP = step_q;

endmodule
